// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR coefficient sequencer and its bench.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam int unsigned NUM_TAPS_DEF = 8;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned COEF_W_DEF   = 16;
  localparam int unsigned OUT_W_DEF    = 32;
  localparam int unsigned FIR_LAT_DEF  = 2;

  // Flush counter must hold NUM_TAPS+FIR_LAT.
  function automatic int unsigned flush_cnt_w(input int unsigned taps, input int unsigned lat);
    return $clog2(taps + lat + 1);
  endfunction

endpackage

// File: rtl/fir_valid_delay.sv
// 1-bit shift line with synchronous clear; carries sample tags alongside the FIR pipeline.
module fir_valid_delay #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) sr <= '0;
    else               sr <= DEPTH'({sr, d});
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fir_coef_sequencer.sv
// Loads a coefficient set into the FIR, flushes its delay line, then streams samples
// and returns tagged results so no output ever mixes coefficient sets.
module fir_coef_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS = NUM_TAPS_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned COEF_W   = COEF_W_DEF,
  parameter int unsigned OUT_W    = OUT_W_DEF,
  parameter int unsigned FIR_LAT  = FIR_LAT_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [COEF_W-1:0] cfg_coef,
  output logic              cfg_done,
  output logic              busy,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [DATA_W-1:0] fir_u_in,
  output logic [ADDR_W-1:0] fir_coef_addr,
  output logic [COEF_W-1:0] fir_coef,
  output logic              fir_we,
  input  logic [OUT_W-1:0]  fir_y,
  output logic              y_valid,
  output logic [OUT_W-1:0]  y_data
);

  localparam int unsigned FLUSH_LEN = NUM_TAPS + FIR_LAT;
  localparam int unsigned FCNT_W    = flush_cnt_w(NUM_TAPS, FIR_LAT);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_TAPS - 1);
  localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_LEN - 1);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic cfg_hs, s_hs, reload;
  logic tag_q, tag_out;

  assign cfg_hs = cfg_valid && cfg_ready;
  assign s_hs   = s_valid && s_ready;
  assign reload = (state_q == RUN) && cfg_start;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_start) state_d = LOAD;
      LOAD:    if (cfg_hs && (cnt_q == LAST_ADDR)) state_d = FLUSH;
      FLUSH:   if (fcnt_q == FLUSH_LAST) state_d = RUN;
      RUN:     if (cfg_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Handshake qualifiers; a reload request blocks the sample in the same cycle.
  always_comb begin
    cfg_ready = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b0;
    case (state_q)
      LOAD: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
      end
      FLUSH:   busy    = 1'b1;
      RUN:     s_ready = !cfg_start;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      fcnt_q <= '0;
    end else begin
      if (state_q != LOAD)                      cnt_q <= '0;
      else if (cfg_hs && (cnt_q != LAST_ADDR))  cnt_q <= cnt_q + 1'b1;
      if (state_q == FLUSH) fcnt_q <= fcnt_q + 1'b1;
      else                  fcnt_q <= '0;
    end
  end

  // FIR-facing registers; bubbles and load/flush cycles feed zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fir_we        <= 1'b0;
      fir_coef_addr <= '0;
      fir_coef      <= '0;
      fir_u_in      <= '0;
      tag_q         <= 1'b0;
      cfg_done      <= 1'b0;
    end else begin
      fir_we   <= cfg_hs;
      if (cfg_hs) begin
        fir_coef_addr <= cnt_q;
        fir_coef      <= cfg_coef;
      end
      fir_u_in <= s_hs ? s_data : '0;
      tag_q    <= s_hs;
      cfg_done <= (state_q == FLUSH) && (fcnt_q == FLUSH_LAST);
    end
  end

  fir_valid_delay #(
    .DEPTH (FIR_LAT)
  ) u_tag_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (reload),
    .d     (tag_q),
    .q     (tag_out)
  );

  // Results still in flight at a reload are dropped here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
    end else begin
      y_valid <= tag_out && !reload;
      if (tag_out && !reload) y_data <= fir_y;
    end
  end

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Randomised bench for fir_coef_sequencer with a behavioural FIR and a convolution reference model.
module tb_fir_coef_sequencer;

  localparam int unsigned NT  = 4;
  localparam int unsigned LAT = 2;
  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 16;
  localparam int unsigned OW  = 32;
  localparam int unsigned AW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_start = 1'b0;
  logic cfg_valid = 1'b0;
  logic [CW-1:0] cfg_coef = '0;
  logic s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic cfg_ready, cfg_done, busy, s_ready, fir_we, y_valid;
  logic [DW-1:0] fir_u_in;
  logic [AW-1:0] fir_coef_addr;
  logic [CW-1:0] fir_coef;
  logic [OW-1:0] fir_y, y_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit model_discard = 1'b0;

  typedef struct {
    longint unsigned val;
    int              due;
  } exp_t;

  exp_t            expq[$];
  longint unsigned hist[$];
  longint unsigned ylog[$];
  longint unsigned mcoef [NT];

  always #5 clk = ~clk;

  fir_coef_sequencer #(
    .NUM_TAPS (NT),
    .DATA_W   (DW),
    .COEF_W   (CW),
    .OUT_W    (OW),
    .FIR_LAT  (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_coef      (cfg_coef),
    .cfg_done      (cfg_done),
    .busy          (busy),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .fir_u_in      (fir_u_in),
    .fir_coef_addr (fir_coef_addr),
    .fir_coef      (fir_coef),
    .fir_we        (fir_we),
    .fir_y         (fir_y),
    .y_valid       (y_valid),
    .y_data        (y_data)
  );

  // Stand-in for the downstream FIR: LAT register stages from u_in to y_out.
  logic [CW-1:0] fcoef [NT];
  logic [DW-1:0] fx [NT-1];
  logic [OW-1:0] fpipe [LAT];
  logic [OW-1:0] y_now;

  always_comb begin
    y_now = OW'(fcoef[0]) * OW'(fir_u_in);
    for (int k = 1; k < NT; k++) y_now = y_now + OW'(fcoef[k]) * OW'(fx[k-1]);
  end

  always @(posedge clk) begin
    if (fir_we) fcoef[fir_coef_addr] <= fir_coef;
    fx[0] <= fir_u_in;
    for (int k = 1; k < NT - 1; k++) fx[k] <= fx[k-1];
    fpipe[0] <= y_now;
    for (int k = 1; k < LAT; k++) fpipe[k] <= fpipe[k-1];
  end

  assign fir_y = fpipe[LAT-1];

  always @(posedge clk) cyc++;

  // Reference: each accepted sample yields sum(coef[k] * stream[n-k]) exactly LAT+2 cycles later.
  always @(negedge clk) begin
    bit hs;
    longint unsigned acc;
    int idx;
    if (mon_en) begin
      hs = (s_valid === 1'b1) && (s_ready === 1'b1) && (rst_n === 1'b1);
      hist.push_back(hs ? longint'(s_data) : 64'd0);
      if (hist.size() > NT) void'(hist.pop_front());
      if (expq.size() > 0 && expq[0].due == cyc) begin
        checks++;
        if (y_valid !== 1'b1 || y_data !== OW'(expq[0].val)) begin
          errors++;
          $display("FAIL y_result cyc %0d: got valid %b data %0d, expected valid 1 data %0d",
                   cyc, y_valid, y_data, expq[0].val);
        end
        void'(expq.pop_front());
      end else begin
        checks++;
        if (y_valid !== 1'b0) begin
          errors++;
          $display("FAIL y_spurious cyc %0d: got valid %b data %0d, expected valid 0", cyc, y_valid, y_data);
        end
      end
      if (y_valid === 1'b1) ylog.push_back(longint'(y_data));
      if (model_discard || !rst_n)
        while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
      if (hs) begin
        acc = 0;
        for (int k = 0; k < NT; k++) begin
          idx = int'(hist.size()) - 1 - k;
          if (idx >= 0) acc += mcoef[k] * hist[idx];
        end
        expq.push_back('{val: acc, due: cyc + LAT + 2});
      end
    end
  end

  task automatic drive_sample(input bit v, input logic [DW-1:0] d);
    @(posedge clk); #1;
    s_valid = v; s_data = d; cfg_start = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_sample(1'b0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cfg_ready, cfg_done, busy, s_ready, fir_we, y_valid} !== 6'b0 || fir_u_in !== '0 ||
        fir_coef_addr !== '0 || fir_coef !== '0 || y_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy/done/busy/srdy/we/yv %b%b%b%b%b%b u %0d y %0d, expected all 0",
               cfg_ready, cfg_done, busy, s_ready, fir_we, y_valid, fir_u_in, y_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_sample(1'b1, DW'($urandom));
      checks++;
      if (s_ready !== 1'b0 || fir_we !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignore: got s_ready %b fir_we %b busy %b cfg_ready %b, expected 0 0 0 0",
                 s_ready, fir_we, busy, cfg_ready);
      end
    end
  endtask

  // Reload request (colliding with a sample), coefficient stream, then flush and done.
  task automatic test_load(input logic [CW-1:0] c [NT], input bit gaps);
    int idx;
    int guard;
    bit prev_hs;
    bit last;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_valid = 1'b0; s_valid = 1'b1; s_data = DW'($urandom); model_discard = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL collision_s_ready: got %b, expected 0", s_ready);
    end
    @(posedge clk); #1;
    model_discard = 1'b0;
    for (int k = 0; k < NT; k++) mcoef[k] = longint'(c[k]);
    idx = 0; guard = 0; prev_hs = 1'b0;
    while (idx < NT && guard < 200) begin
      cfg_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_coef  = cfg_valid ? c[idx] : CW'($urandom);
      cfg_start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      s_valid   = 1'($urandom_range(0, 1));
      s_data    = DW'($urandom);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || cfg_ready !== 1'b1 || s_ready !== 1'b0 || fir_u_in !== '0) begin
        errors++;
        $display("FAIL load_state: got busy %b cfg_ready %b s_ready %b u %0d, expected 1 1 0 0",
                 busy, cfg_ready, s_ready, fir_u_in);
      end
      checks++;
      if (fir_we !== prev_hs ||
          (prev_hs && (fir_coef_addr !== AW'(idx - 1) || fir_coef !== c[idx-1]))) begin
        errors++;
        $display("FAIL load_write: got we %b addr %0d coef %0d, expected we %b addr %0d coef %0d",
                 fir_we, fir_coef_addr, fir_coef, prev_hs, idx - 1, prev_hs ? c[idx-1] : 0);
      end
      prev_hs = cfg_valid;
      if (cfg_valid) idx++;
      guard++;
      @(posedge clk); #1;
    end
    if (idx < NT) begin
      errors++; checks++;
      $display("FAIL load_timeout: got %0d coefficients accepted, expected %0d", idx, NT);
    end
    for (int k = 0; k <= NT + LAT; k++) begin
      last      = (k == NT + LAT);
      cfg_valid = last ? 1'b0 : 1'($urandom_range(0, 1));
      cfg_start = last ? 1'b0 : 1'($urandom_range(0, 1));
      s_valid   = last ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (fir_we !== (k == 0) ||
          (k == 0 && (fir_coef_addr !== AW'(NT - 1) || fir_coef !== c[NT-1]))) begin
        errors++;
        $display("FAIL flush_write k %0d: got we %b addr %0d coef %0d, expected we %b", k, fir_we,
                 fir_coef_addr, fir_coef, k == 0);
      end
      checks++;
      if (cfg_done !== last || busy !== !last || cfg_ready !== 1'b0 || fir_u_in !== '0 || s_ready !== last) begin
        errors++;
        $display("FAIL flush_state k %0d: got done %b busy %b cfg_ready %b u %0d s_ready %b, expected %b %b 0 0 %b",
                 k, cfg_done, busy, cfg_ready, fir_u_in, s_ready, last, !last, last);
      end
      if (!last) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_impulse_coefs();
    logic [CW-1:0] cf [NT];
    cf = '{16'd1, 16'd0, 16'd0, 16'd0};
    test_load(cf, 1'b1);
    ylog.delete();
    drive_sample(1'b1, 16'd5);
    drive_sample(1'b1, 16'd6);
    drive_sample(1'b1, 16'd7);
    idle(LAT + 4);
    checks++;
    if (ylog.size() != 3 || ylog[0] != 5 || ylog[1] != 6 || ylog[2] != 7) begin
      errors++;
      $display("FAIL impulse_passthrough: got %0d results (first %0d), expected 5,6,7", ylog.size(),
               ylog.size() > 0 ? ylog[0] : 0);
    end
  endtask

  task automatic test_taps();
    logic [CW-1:0] cf [NT];
    cf = '{16'd1, 16'd2, 16'd3, 16'd4};
    test_load(cf, 1'b0);
    ylog.delete();
    drive_sample(1'b1, 16'd1);
    for (int i = 0; i < 4; i++) drive_sample(1'b1, 16'd0);
    idle(LAT + 4);
    checks++;
    if (ylog.size() != 5 || ylog[0] != 1 || ylog[1] != 2 || ylog[2] != 3 || ylog[3] != 4 || ylog[4] != 0) begin
      errors++;
      $display("FAIL tap_response: got %0d results (first %0d), expected 1,2,3,4,0", ylog.size(),
               ylog.size() > 0 ? ylog[0] : 0);
    end
  endtask

  task automatic test_reload_midstream();
    logic [CW-1:0] cf [NT];
    cf = '{16'd2, 16'd0, 16'd0, 16'd0};
    ylog.delete();
    drive_sample(1'b1, DW'($urandom_range(1, 255)));
    drive_sample(1'b1, DW'($urandom_range(1, 255)));
    test_load(cf, 1'b1);
    checks++;
    if (ylog.size() != 0) begin
      errors++;
      $display("FAIL reload_discard: got %0d results, expected 0", ylog.size());
    end
    drive_sample(1'b1, 16'd3);
    idle(LAT + 4);
    checks++;
    if (ylog.size() != 1 || ylog[0] != 6) begin
      errors++;
      $display("FAIL reload_new_coefs: got %0d results (first %0d), expected one result 6", ylog.size(),
               ylog.size() > 0 ? ylog[0] : 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] ca [NT];
    logic [CW-1:0] cb [NT];
    for (int k = 0; k < NT; k++) begin
      ca[k] = CW'($urandom_range(0, 255));
      cb[k] = CW'($urandom_range(0, 255));
    end
    test_load(ca, 1'b0);
    test_load(cb, 1'b1);
    for (int i = 0; i < 6; i++) drive_sample(1'b1, DW'($urandom_range(0, 255)));
    idle(LAT + 4);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_drain: got %0d pending results, expected 0", expq.size());
    end
  endtask

  task automatic test_random_stream();
    logic [CW-1:0] cf [NT];
    for (int k = 0; k < NT; k++) cf[k] = CW'($urandom_range(0, 255));
    test_load(cf, 1'b1);
    for (int i = 0; i < 40; i++) begin
      drive_sample(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL run_ready: got s_ready %b busy %b, expected 1 0", s_ready, busy);
      end
    end
    idle(LAT + 4);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: got %0d pending results, expected 0", expq.size());
    end
  endtask

  task automatic test_reset_midload();
    logic [CW-1:0] cf [NT];
    cf = '{16'd3, 16'd0, 16'd0, 16'd0};
    @(posedge clk); #1;
    cfg_start = 1'b1; s_valid = 1'b0; model_discard = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0; model_discard = 1'b0; cfg_valid = 1'b1; cfg_coef = 16'd9;
    @(posedge clk); #1;
    cfg_coef = 16'd8;
    @(posedge clk); #1;
    cfg_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({cfg_ready, cfg_done, busy, s_ready, fir_we, y_valid} !== 6'b0 || fir_u_in !== '0 ||
        fir_coef_addr !== '0 || fir_coef !== '0 || y_data !== '0) begin
      errors++;
      $display("FAIL midload_reset: got rdy/done/busy/srdy/we/yv %b%b%b%b%b%b addr %0d coef %0d y %0d, expected all 0",
               cfg_ready, cfg_done, busy, s_ready, fir_we, y_valid, fir_coef_addr, fir_coef, y_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_sample(1'b1, DW'($urandom));
      checks++;
      if (s_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midload_idle: got s_ready %b busy %b, expected 0 0", s_ready, busy);
      end
    end
    test_load(cf, 1'b1);
    ylog.delete();
    drive_sample(1'b1, 16'd7);
    idle(LAT + 4);
    checks++;
    if (ylog.size() != 1 || ylog[0] != 21) begin
      errors++;
      $display("FAIL midload_reload: got %0d results (first %0d), expected one result 21", ylog.size(),
               ylog.size() > 0 ? ylog[0] : 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_impulse_coefs();
    test_taps();
    test_reload_midstream();
    test_back_to_back();
    test_random_stream();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
